// File: rtl/load_store_unit.sv
// Load/store unit: one bus transaction per memory instruction.
// Builds byte enables and lane data, then aligns and extends load data.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        misaligned,
   output logic        access_fault,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_t;

   localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic        load_q;

   logic        start;
   logic        fault;
   logic        mis;
   logic        sz_b;
   logic        sz_h;
   logic        sz_w;
   logic [3:0]  be_n;
   logic [31:0] wd_n;
   logic [31:0] lane;
   logic [31:0] ld;

   // Classify the incoming request and build its bus fields
   always_comb begin
      start = mem_read | mem_write;
      sz_b  = (funct3[1:0] == 2'b00);
      sz_h  = (funct3[1:0] == 2'b01);
      sz_w  = (funct3[1:0] == 2'b10);
      fault = (mem_read & mem_write)
            | (mem_read & ((funct3 == 3'b011) | (funct3[2:1] == 2'b11)))
            | (mem_write & (funct3[2] | (funct3 == 3'b011)));
      mis   = (sz_h & addr[0]) | (sz_w & (addr[1:0] != 2'b00));
      be_n  = 4'b0000;
      wd_n  = 32'h0;
      unique case (1'b1)
         sz_b: begin
            be_n = 4'b0001 << addr[1:0];
            wd_n = {4{wdata[7:0]}};
         end
         sz_h: begin
            be_n = addr[1] ? 4'b1100 : 4'b0011;
            wd_n = {2{wdata[15:0]}};
         end
         default: begin
            be_n = 4'b1111;
            wd_n = wdata;
         end
      endcase
   end

   // Shift the addressed lane down and extend it by access type
   always_comb begin
      lane = bus_rdata >> {off_q, 3'b000};
      unique case (f3_q)
         3'b000:  ld = {{24{lane[7]}}, lane[7:0]};
         3'b100:  ld = {24'h0, lane[7:0]};
         3'b001:  ld = {{16{lane[15]}}, lane[15:0]};
         3'b101:  ld = {16'h0, lane[15:0]};
         default: ld = lane;
      endcase
   end

   // Hold the core while a request is being accepted or is on the bus
   always_comb begin
      stall = (state == REQ) | ((state == IDLE) & start);
   end

   // Transaction sequencer with registered bus fields and result flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= 8'h0;
         f3_q         <= 3'b000;
         off_q        <= 2'b00;
         load_q       <= 1'b0;
         bus_req      <= 1'b0;
         bus_we       <= 1'b0;
         bus_addr     <= 32'h0;
         bus_be       <= 4'h0;
         bus_wdata    <= 32'h0;
         rdata        <= 32'h0;
         misaligned   <= 1'b0;
         access_fault <= 1'b0;
      end else begin
         misaligned   <= 1'b0;
         access_fault <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (fault) begin
                     access_fault <= 1'b1;
                     if (mem_read) rdata <= 32'h0;
                     state <= DONE;
                  end else if (mis) begin
                     misaligned <= 1'b1;
                     if (mem_read) rdata <= 32'h0;
                     state <= DONE;
                  end else begin
                     bus_req   <= 1'b1;
                     bus_we    <= mem_write;
                     bus_addr  <= {addr[31:2], 2'b00};
                     bus_be    <= be_n;
                     bus_wdata <= wd_n;
                     f3_q      <= funct3;
                     off_q     <= addr[1:0];
                     load_q    <= mem_read;
                     cnt       <= 8'h0;
                     state     <= REQ;
                  end
               end
            end
            REQ: begin
               if (bus_ready) begin
                  bus_req <= 1'b0;
                  bus_we  <= 1'b0;
                  if (load_q) rdata <= ld;
                  state <= DONE;
               end else if (cnt == LAST) begin
                  bus_req      <= 1'b0;
                  bus_we       <= 1'b0;
                  access_fault <= 1'b1;
                  if (load_q) rdata <= 32'h0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 8'h1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model drives expectations,
// one negedge process compares, plus literal checks on key results.
module tb_load_store_unit;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata;
   logic        stall;
   logic [31:0] rdata;
   logic        misaligned, access_fault;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset(reset),
      .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .wdata(wdata),
      .stall(stall), .rdata(rdata),
      .misaligned(misaligned), .access_fault(access_fault),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ready(bus_ready), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic        chk_en = 1'b0;
   logic        e_stall, e_req, e_we, e_mis, e_fault;
   logic [31:0] e_addr, e_wdata, e_rdata;
   logic [3:0]  e_be;
   logic [31:0] m_rdata;

   int          stall_cnt = 0, req_cnt = 0, mis_cnt = 0, flt_cnt = 0;
   logic [3:0]  cap_be;
   logic [31:0] cap_addr, cap_wdata;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // 0 ok, 1 fault, 2 misaligned
   function automatic int kind(input logic rd, input logic wr,
                               input logic [2:0] f, input logic [31:0] a);
      int sz;
      sz = int'(f) % 4;
      if (rd && wr) return 1;
      if (rd && (f == 3 || f == 6 || f == 7)) return 1;
      if (wr && (f >= 4 || f == 3)) return 1;
      if (sz == 1 && a % 2 != 0) return 2;
      if (sz == 2 && a % 4 != 0) return 2;
      return 0;
   endfunction

   function automatic logic [3:0] be_of(input logic [2:0] f,
                                        input logic [31:0] a);
      int sz;
      sz = int'(f) % 4;
      if (sz == 0) return 4'(1 << (a % 4));
      if (sz == 1) return (a % 4 >= 2) ? 4'd12 : 4'd3;
      return 4'd15;
   endfunction

   function automatic logic [31:0] wd_of(input logic [2:0] f,
                                         input logic [31:0] w);
      int sz;
      sz = int'(f) % 4;
      if (sz == 0) return (w % 256) * 32'h01010101;
      if (sz == 1) return (w % 65536) * 32'h00010001;
      return w;
   endfunction

   function automatic logic [31:0] ld_of(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] word);
      logic [31:0] v;
      v = word >> (8 * (a % 4));
      case (f)
         3'd0: begin
            v = v % 256;
            if (v >= 128) v = v - 32'd256;
         end
         3'd4: v = v % 256;
         3'd1: begin
            v = v % 65536;
            if (v >= 32768) v = v - 32'd65536;
         end
         3'd5: v = v % 65536;
         default: ;
      endcase
      return v;
   endfunction

   always @(negedge clk) begin
      if (stall) stall_cnt++;
      if (misaligned) mis_cnt++;
      if (access_fault) flt_cnt++;
      if (bus_req) begin
         req_cnt++;
         cap_be    = bus_be;
         cap_addr  = bus_addr;
         cap_wdata = bus_wdata;
      end
      if (chk_en) begin
         check("stall", 32'(stall), 32'(e_stall));
         check("bus_req", 32'(bus_req), 32'(e_req));
         check("misaligned", 32'(misaligned), 32'(e_mis));
         check("access_fault", 32'(access_fault), 32'(e_fault));
         check("rdata", rdata, e_rdata);
         if (e_req) begin
            check("bus_we", 32'(bus_we), 32'(e_we));
            check("bus_addr", bus_addr, e_addr);
            check("bus_be", 32'(bus_be), 32'(e_be));
            check("bus_wdata", bus_wdata, e_wdata);
         end
      end
   end

   task automatic run(input logic rd, input logic wr, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] w,
                      input int dly, input logic [31:0] word);
      int  k;
      logic to;
      k  = kind(rd, wr, f, a);
      to = 1'b0;
      mem_read = rd; mem_write = wr; funct3 = f; addr = a; wdata = w;
      bus_ready = 1'b0; bus_rdata = 32'h0;
      e_stall = 1'b1; e_req = 1'b0; e_mis = 1'b0; e_fault = 1'b0;
      e_rdata = m_rdata;
      @(posedge clk); #1;
      if (k == 0) begin
         e_req = 1'b1; e_we = wr; e_addr = a - a % 4;
         e_be = be_of(f, a); e_wdata = wd_of(f, w);
         addr = ~a; wdata = ~w;
         for (int i = 0; i < T; i++) begin
            bus_ready = (i == dly);
            bus_rdata = (i == dly) ? word : 32'h5A5AA5A5;
            @(posedge clk); #1;
            if (i == dly) begin
               if (rd) m_rdata = ld_of(f, a, word);
               break;
            end
            if (i == T - 1) begin
               to = 1'b1;
               if (rd) m_rdata = 32'h0;
            end
         end
      end else if (rd) begin
         m_rdata = 32'h0;
      end
      bus_ready = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      e_stall = 1'b0; e_req = 1'b0;
      e_mis = (k == 2); e_fault = (k == 1) || to;
      e_rdata = m_rdata;
      @(posedge clk); #1;
      e_mis = 1'b0; e_fault = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int s0, r0, mi0, f0;
      reset = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
      addr = 32'h0; wdata = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
      m_rdata = 32'h0;
      e_stall = 1'b0; e_req = 1'b0; e_we = 1'b0; e_mis = 1'b0;
      e_fault = 1'b0; e_addr = 32'h0; e_wdata = 32'h0; e_rdata = 32'h0;
      e_be = 4'h0;
      repeat (2) @(negedge clk);
      check("rst_stall", 32'(stall), 32'h0);
      check("rst_bus_req", 32'(bus_req), 32'h0);
      check("rst_bus_we", 32'(bus_we), 32'h0);
      check("rst_bus_addr", bus_addr, 32'h0);
      check("rst_bus_be", 32'(bus_be), 32'h0);
      check("rst_bus_wdata", bus_wdata, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_flags", 32'({misaligned, access_fault}), 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      chk_en = 1'b1;
      @(posedge clk); #1;

      s0 = stall_cnt;
      run(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 2, 32'h0);
      check("sw_stall_cycles", 32'(stall_cnt - s0), 32'd4);
      check("sw_be", 32'(cap_be), 32'hF);
      check("sw_addr", cap_addr, 32'h100);

      run(0, 1, 3'd0, 32'h103, 32'h000000A5, 0, 32'h0);
      check("sb_be", 32'(cap_be), 32'h8);
      check("sb_wdata", cap_wdata, 32'hA5A5A5A5);
      check("sb_addr", cap_addr, 32'h100);

      run(0, 1, 3'd1, 32'h102, 32'h1234ABCD, 1, 32'h0);
      check("sh_be", 32'(cap_be), 32'hC);
      check("sh_wdata", cap_wdata, 32'hABCDABCD);

      run(1, 0, 3'd0, 32'h202, 32'h0, 1, 32'h12F03456);
      check("lb_rdata", rdata, 32'hFFFFFFF0);
      run(1, 0, 3'd4, 32'h202, 32'h0, 0, 32'h12F03456);
      check("lbu_rdata", rdata, 32'h000000F0);
      run(1, 0, 3'd1, 32'h202, 32'h0, 2, 32'h12F03456);
      check("lh_rdata", rdata, 32'h000012F0);

      s0 = stall_cnt; r0 = req_cnt; mi0 = mis_cnt;
      run(1, 0, 3'd2, 32'h6, 32'h0, 0, 32'h0);
      check("lw_mis_stall", 32'(stall_cnt - s0), 32'd1);
      check("lw_mis_noreq", 32'(req_cnt - r0), 32'd0);
      check("lw_mis_pulse", 32'(mis_cnt - mi0), 32'd1);
      check("lw_mis_rdata", rdata, 32'h0);

      run(1, 0, 3'd5, 32'h200, 32'h0, 0, 32'h8001FFFE);
      check("lhu_rdata", rdata, 32'h0000FFFE);
      run(1, 0, 3'd1, 32'h200, 32'h0, 1, 32'h8001FFFE);
      check("lh_neg_rdata", rdata, 32'hFFFFFFFE);
      run(1, 0, 3'd0, 32'h201, 32'h0, 0, 32'h8001FFFE);
      run(0, 1, 3'd2, 32'h101, 32'h11111111, 0, 32'h0);
      run(0, 1, 3'd1, 32'h105, 32'h22222222, 0, 32'h0);
      run(0, 1, 3'd4, 32'h100, 32'h33333333, 0, 32'h0);
      check("st_fault_keeps_rdata", rdata, 32'hFFFFFFFF);

      run(1, 0, 3'd2, 32'h300, 32'h0, 0, 32'hCAFEF00D);
      check("lw_rdata", rdata, 32'hCAFEF00D);
      r0 = req_cnt; f0 = flt_cnt;
      run(1, 0, 3'd2, 32'h300, 32'h0, 99, 32'h0);
      check("to_req_cycles", 32'(req_cnt - r0), 32'd4);
      check("to_fault_pulse", 32'(flt_cnt - f0), 32'd1);
      check("to_rdata", rdata, 32'h0);

      run(1, 0, 3'd2, 32'h304, 32'h0, 3, 32'h0BADF00D);
      check("lw_late_ready", rdata, 32'h0BADF00D);
      r0 = req_cnt; f0 = flt_cnt;
      run(1, 0, 3'd3, 32'h304, 32'h0, 0, 32'h0);
      check("f3_011_noreq", 32'(req_cnt - r0), 32'd0);
      check("f3_011_fault", 32'(flt_cnt - f0), 32'd1);
      run(1, 0, 3'd7, 32'h301, 32'h0, 0, 32'h0);
      run(1, 1, 3'd2, 32'h300, 32'h0, 0, 32'h0);
      run(0, 1, 3'd2, 32'h300, 32'h44444444, 99, 32'h0);
      run(1, 0, 3'd2, 32'h308, 32'h0, 0, 32'h76543210);

      chk_en = 1'b0;
      mem_read = 1'b1; funct3 = 3'd2; addr = 32'h400; bus_ready = 1'b0;
      @(posedge clk); #1;
      check("mid_req_busreq", 32'(bus_req), 32'h1);
      @(negedge clk); #2;
      reset = 1'b1; mem_read = 1'b0;
      #1;
      check("rst_async_busreq", 32'(bus_req), 32'h0);
      check("rst_async_stall", 32'(stall), 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      m_rdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_quiet",
               32'({bus_req, misaligned, access_fault, stall}), 32'h0);
      end
      @(posedge clk); #1;
      e_stall = 1'b0; e_req = 1'b0; e_mis = 1'b0; e_fault = 1'b0;
      e_rdata = m_rdata;
      chk_en = 1'b1;
      run(1, 0, 3'd4, 32'h403, 32'h0, 1, 32'h9A000000);
      check("post_rst_lbu", rdata, 32'h0000009A);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
